audio_frame_scheduler: RTL and testbench

Per-frame scheduler between the I2S codec interface and a shared HRTF/DSP engine. On each `new_sample_pulse` it captures the received stereo sample and forms a mono input. It then issues one job per enabled virtual source to the engine, one at a time, and accumulates the returned L/R contributions. It presents the saturated mix to the I2S transmit inputs at the next frame boundary. Overruns, where the engine cannot finish all sources within one frame, are detected, counted and recovered from without breaking the job handshake.

---
 rtl/audio_frame_scheduler_if.sv | 25 ++
 rtl/audio_frame_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_audio_frame_scheduler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_frame_scheduler_if.sv
// Job/result handshake between the frame scheduler and the shared HRTF/DSP engine.
// The scheduler is the master (issues jobs); the engine is the slave (returns results).
interface audio_frame_scheduler_if #(
    parameter int unsigned NUM_SRC = 4
);
    localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic                    job_valid;
    logic                    job_ready;
    logic [SRC_W-1:0]        job_src;
    logic signed [23:0]      job_sample;
    logic                    res_valid;
    logic signed [23:0]      res_l;
    logic signed [23:0]      res_r;

    modport master (
        output job_valid, job_src, job_sample,
        input  job_ready, res_valid, res_l, res_r
    );

    modport slave (
        input  job_valid, job_src, job_sample,
        output job_ready, res_valid, res_l, res_r
    );
endinterface

// File: rtl/audio_frame_scheduler.sv
// Per-frame scheduler: captures the I2S sample, issues one engine job per enabled source,
// accumulates L/R results and presents the saturated mix at the next frame boundary.
module audio_frame_scheduler #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ACC_W   = 26
) (
    input  logic                   clk_audio,
    input  logic                   reset,
    input  logic                   new_sample_pulse,
    input  logic signed [23:0]     l_data_rx,
    input  logic signed [23:0]     r_data_rx,
    output logic signed [23:0]     l_data_tx,
    output logic signed [23:0]     r_data_tx,
    input  logic [NUM_SRC-1:0]     src_enable,
    audio_frame_scheduler_if.master eng,
    output logic                   busy,
    output logic                   overrun,
    output logic [7:0]             overrun_cnt,
    output logic [15:0]            frame_count
);
    localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SAT, DONE, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [SRC_W-1:0]          src_q, src_d;
    logic [NUM_SRC-1:0]        en_q, en_d;
    logic signed [ACC_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [23:0]        pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic signed [23:0]        tx_l_q, tx_l_d, tx_r_q, tx_r_d;
    logic signed [23:0]        smp_q, smp_d, nxt_smp_q, nxt_smp_d;
    logic                      abort_q, abort_d;
    logic                      overrun_q, overrun_d;
    logic [7:0]                ovr_cnt_q, ovr_cnt_d;
    logic [15:0]               frame_q, frame_d;

    logic [24:0]               rx_sum;
    logic signed [23:0]        mono;
    logic [SRC_W:0]            first_new, first_cur, next_cur;

    // Returns {found, index} of the lowest enabled source at or above 'from'.
    function automatic logic [SRC_W:0] find_en(input logic [NUM_SRC-1:0] en,
                                               input logic [SRC_W:0] from);
        logic [SRC_W:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!r[SRC_W] && en[i] && (i >= 32'(from)))
                r = {1'b1, SRC_W'(i)};
        end
        return r;
    endfunction

    function automatic logic signed [23:0] clamp24(input logic signed [ACC_W-1:0] a);
        if (a[ACC_W-1:23] == '0 || a[ACC_W-1:23] == '1)
            return a[23:0];
        else
            return a[ACC_W-1] ? 24'sh800000 : 24'sh7FFFFF;
    endfunction

    always_comb begin
        rx_sum    = {l_data_rx[23], l_data_rx} + {r_data_rx[23], r_data_rx};
        mono      = rx_sum[24:1];
        first_new = find_en(src_enable, '0);
        first_cur = find_en(en_q, '0);
        next_cur  = find_en(en_q, {1'b0, src_q} + (SRC_W+1)'(1));
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        en_d      = en_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        pend_l_d  = pend_l_q;
        pend_r_d  = pend_r_q;
        tx_l_d    = tx_l_q;
        tx_r_d    = tx_r_q;
        smp_d     = smp_q;
        nxt_smp_d = nxt_smp_q;
        abort_d   = abort_q;
        overrun_d = 1'b0;
        ovr_cnt_d = ovr_cnt_q;
        frame_d   = frame_q;

        // A pulse always opens a new frame; in a busy state it is also an overrun.
        if (new_sample_pulse) begin
            frame_d   = frame_q + 16'd1;
            en_d      = src_enable;
            nxt_smp_d = mono;
            acc_l_d   = '0;
            acc_r_d   = '0;
            if (state_q != ISSUE)
                smp_d = mono;
            if (state_q == IDLE || state_q == DONE) begin
                tx_l_d = pend_l_q;
                tx_r_d = pend_r_q;
            end else begin
                overrun_d = 1'b1;
                if (ovr_cnt_q != 8'hFF)
                    ovr_cnt_d = ovr_cnt_q + 8'd1;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (new_sample_pulse) begin
                    if (first_new[SRC_W]) begin
                        src_d   = first_new[SRC_W-1:0];
                        state_d = ISSUE;
                    end else begin
                        pend_l_d = '0;
                        pend_r_d = '0;
                        state_d  = DONE;
                    end
                end
            end
            ISSUE: begin
                if (new_sample_pulse)
                    abort_d = 1'b1;
                if (eng.job_ready)
                    state_d = (abort_q || new_sample_pulse) ? DRAIN : WAIT;
            end
            WAIT: begin
                if (new_sample_pulse) begin
                    if (!eng.res_valid)
                        state_d = DRAIN;
                    else if (first_new[SRC_W]) begin
                        src_d   = first_new[SRC_W-1:0];
                        state_d = ISSUE;
                    end else begin
                        pend_l_d = '0;
                        pend_r_d = '0;
                        state_d  = DONE;
                    end
                end else if (eng.res_valid) begin
                    acc_l_d = acc_l_q + {{(ACC_W-24){eng.res_l[23]}}, eng.res_l};
                    acc_r_d = acc_r_q + {{(ACC_W-24){eng.res_r[23]}}, eng.res_r};
                    if (next_cur[SRC_W]) begin
                        src_d   = next_cur[SRC_W-1:0];
                        state_d = ISSUE;
                    end else begin
                        state_d = SAT;
                    end
                end
            end
            SAT: begin
                if (new_sample_pulse) begin
                    if (first_new[SRC_W]) begin
                        src_d   = first_new[SRC_W-1:0];
                        state_d = ISSUE;
                    end else begin
                        pend_l_d = '0;
                        pend_r_d = '0;
                        state_d  = DONE;
                    end
                end else begin
                    pend_l_d = clamp24(acc_l_q);
                    pend_r_d = clamp24(acc_r_q);
                    state_d  = DONE;
                end
            end
            DRAIN: begin
                // The sample of the newest frame was parked while an aborted job was held.
                if (!new_sample_pulse && eng.res_valid) begin
                    abort_d = 1'b0;
                    smp_d   = nxt_smp_q;
                    if (first_cur[SRC_W]) begin
                        src_d   = first_cur[SRC_W-1:0];
                        state_d = ISSUE;
                    end else begin
                        pend_l_d = '0;
                        pend_r_d = '0;
                        state_d  = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_audio) begin
        if (reset) begin
            state_q   <= IDLE;
            src_q     <= '0;
            en_q      <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            pend_l_q  <= '0;
            pend_r_q  <= '0;
            tx_l_q    <= '0;
            tx_r_q    <= '0;
            smp_q     <= '0;
            nxt_smp_q <= '0;
            abort_q   <= 1'b0;
            overrun_q <= 1'b0;
            ovr_cnt_q <= '0;
            frame_q   <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            en_q      <= en_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            pend_l_q  <= pend_l_d;
            pend_r_q  <= pend_r_d;
            tx_l_q    <= tx_l_d;
            tx_r_q    <= tx_r_d;
            smp_q     <= smp_d;
            nxt_smp_q <= nxt_smp_d;
            abort_q   <= abort_d;
            overrun_q <= overrun_d;
            ovr_cnt_q <= ovr_cnt_d;
            frame_q   <= frame_d;
        end
    end

    assign eng.job_valid  = (state_q == ISSUE);
    assign eng.job_src    = src_q;
    assign eng.job_sample = smp_q;
    assign busy        = (state_q == ISSUE) || (state_q == WAIT) ||
                         (state_q == SAT)   || (state_q == DRAIN);
    assign overrun     = overrun_q;
    assign overrun_cnt = ovr_cnt_q;
    assign frame_count = frame_q;
    assign l_data_tx   = tx_l_q;
    assign r_data_tx   = tx_r_q;
endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Directed bench for audio_frame_scheduler with an engine model and a job scoreboard.
module tb_audio_frame_scheduler;
    localparam int unsigned NUM_SRC = 4;

    logic               clk_audio = 1'b0;
    logic               reset;
    logic               new_sample_pulse;
    logic signed [23:0] l_rx, r_rx;
    logic signed [23:0] l_tx, r_tx;
    logic [3:0]         en_in;
    logic               busy, overrun;
    logic [7:0]         overrun_cnt;
    logic [15:0]        frame_count;

    logic               ready_en;
    int                 mode;
    int                 stall_src;
    int                 stall_lat;
    int                 n_assert = 0;
    int                 n_fail   = 0;

    logic [23:0]        exp_src_q[$];
    logic [23:0]        exp_smp_q[$];

    always #5 clk_audio = ~clk_audio;

    audio_frame_scheduler_if #(.NUM_SRC(NUM_SRC)) bif ();
    assign bif.job_ready = ready_en;

    audio_frame_scheduler #(.NUM_SRC(NUM_SRC), .ACC_W(26)) dut (
        .clk_audio        (clk_audio),
        .reset            (reset),
        .new_sample_pulse (new_sample_pulse),
        .l_data_rx        (l_rx),
        .r_data_rx        (r_rx),
        .l_data_tx        (l_tx),
        .r_data_tx        (r_tx),
        .src_enable       (en_in),
        .eng              (bif.master),
        .busy             (busy),
        .overrun          (overrun),
        .overrun_cnt      (overrun_cnt),
        .frame_count      (frame_count)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_job(input int src, input logic [23:0] smp);
        exp_src_q.push_back(24'(src));
        exp_smp_q.push_back(smp);
    endtask

    task automatic pulse_frame(input logic signed [23:0] l, input logic signed [23:0] r,
                               input logic [3:0] en);
        @(negedge clk_audio);
        new_sample_pulse = 1'b1;
        l_rx  = l;
        r_rx  = r;
        en_in = en;
        @(negedge clk_audio);
        new_sample_pulse = 1'b0;
    endtask

    // Engine model: accepts a job, answers after a fixed latency (or a one-shot stall).
    initial begin
        int          cnt;
        logic [23:0] rl, rr;
        cnt = 0;
        rl  = '0;
        rr  = '0;
        bif.res_valid = 1'b0;
        bif.res_l     = '0;
        bif.res_r     = '0;
        forever begin
            @(negedge clk_audio);
            #2;
            bif.res_valid = 1'b0;
            if (reset) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bif.res_l     = rl;
                    bif.res_r     = rr;
                    bif.res_valid = 1'b1;
                end
            end else if (bif.job_valid && bif.job_ready) begin
                if (exp_src_q.size() == 0) begin
                    chk("unexpected_job", 24'(bif.job_src), 24'hFFFFFF);
                end else begin
                    chk("job_src", 24'(bif.job_src), exp_src_q.pop_front());
                    chk("job_sample", bif.job_sample, exp_smp_q.pop_front());
                end
                if (mode == 1) begin
                    rl = 24'h7FFFFF;
                    rr = 24'h800000;
                end else begin
                    rl = 24'(100 * (int'(bif.job_src) + 1));
                    rr = rl;
                end
                if (stall_src == int'(bif.job_src)) begin
                    cnt = stall_lat;
                    stall_src = -1;
                end else begin
                    cnt = 3;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        new_sample_pulse = 1'b0;
        l_rx = '0;
        r_rx = '0;
        en_in = '0;
        ready_en = 1'b1;
        mode = 0;
        stall_src = -1;
        stall_lat = 3;
        repeat (3) @(negedge clk_audio);
        chk("rst_tx_l", l_tx, 24'd0);
        chk("rst_tx_r", r_tx, 24'd0);
        chk("rst_job_valid", 24'(bif.job_valid), 24'd0);
        chk("rst_busy", 24'(busy), 24'd0);
        chk("rst_ovr_cnt", 24'(overrun_cnt), 24'd0);
        chk("rst_frame_cnt", 24'(frame_count), 24'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk_audio);

        // Frame 1: basic mix, all sources
        for (int i = 0; i < 4; i++) push_job(i, 24'd2000);
        pulse_frame(24'sd1000, 24'sd3000, 4'b1111);
        chk("f1_tx_l", l_tx, 24'd0);
        chk("f1_frame_cnt", 24'(frame_count), 24'd1);
        chk("f1_job_sample", bif.job_sample, 24'd2000);
        chk("f1_job_valid", 24'(bif.job_valid), 24'd1);
        chk("f1_busy", 24'(busy), 24'd1);
        repeat (500) @(negedge clk_audio);
        chk("f1_idle_busy", 24'(busy), 24'd0);

        // Frame 2: sparse enables and rounding toward -inf
        push_job(1, -24'sd2);
        push_job(3, -24'sd2);
        pulse_frame(-24'sd3, 24'sd0, 4'b1010);
        chk("f2_tx_l", l_tx, 24'd1000);
        chk("f2_tx_r", r_tx, 24'd1000);
        chk("f2_job_sample", bif.job_sample, -24'sd2);
        chk("f2_job_src", 24'(bif.job_src), 24'd1);
        repeat (500) @(negedge clk_audio);

        // Frame 3: nothing enabled
        pulse_frame(24'sd5, 24'sd5, 4'b0000);
        chk("f3_tx_l", l_tx, 24'd600);
        chk("f3_tx_r", r_tx, 24'd600);
        chk("f3_busy", 24'(busy), 24'd0);
        chk("f3_frame_cnt", 24'(frame_count), 24'd3);
        repeat (500) @(negedge clk_audio);

        // Frame 4: saturating engine results
        mode = 1;
        for (int i = 0; i < 4; i++) push_job(i, 24'd0);
        pulse_frame(24'sd0, 24'sd0, 4'b1111);
        chk("f4_tx_l", l_tx, 24'd0);
        chk("f4_tx_r", r_tx, 24'd0);
        repeat (500) @(negedge clk_audio);

        // Frame 5: engine stalls on source 2 past the frame boundary
        mode = 0;
        stall_lat = 600;
        stall_src = 2;
        for (int i = 0; i < 3; i++) push_job(i, 24'd15);
        pulse_frame(24'sd10, 24'sd20, 4'b1111);
        chk("f5_tx_l_sat", l_tx, 24'h7FFFFF);
        chk("f5_tx_r_sat", r_tx, 24'h800000);
        repeat (500) @(negedge clk_audio);
        chk("f5_busy_stalled", 24'(busy), 24'd1);
        chk("f5_ovr_cnt", 24'(overrun_cnt), 24'd0);

        // Frame 6: overrun in WAIT, drain then reissue from source 0
        for (int i = 0; i < 4; i++) push_job(i, 24'd3);
        pulse_frame(24'sd2, 24'sd4, 4'b1111);
        chk("f6_overrun", 24'(overrun), 24'd1);
        chk("f6_ovr_cnt", 24'(overrun_cnt), 24'd1);
        chk("f6_tx_l_held", l_tx, 24'h7FFFFF);
        chk("f6_tx_r_held", r_tx, 24'h800000);
        chk("f6_frame_cnt", 24'(frame_count), 24'd6);
        chk("f6_drain_busy", 24'(busy), 24'd1);
        chk("f6_drain_no_job", 24'(bif.job_valid), 24'd0);
        @(negedge clk_audio);
        chk("f6_overrun_pulse_end", 24'(overrun), 24'd0);
        repeat (500) @(negedge clk_audio);

        // Frame 7: engine backpressure holds the first job across the next pulse
        ready_en = 1'b0;
        push_job(0, 24'd100);
        pulse_frame(24'sd100, 24'sd100, 4'b0011);
        chk("f7_tx_l", l_tx, 24'd1000);
        chk("f7_tx_r", r_tx, 24'd1000);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_audio);
            chk("f7_hold", {busy, bif.job_valid, 2'(bif.job_src), bif.job_sample[19:0]},
                {1'b1, 1'b1, 2'd0, 20'd100});
        end

        // Frame 8: overrun while the job is still unaccepted
        push_job(2, -24'sd100);
        push_job(3, -24'sd100);
        pulse_frame(-24'sd100, -24'sd100, 4'b1100);
        chk("f8_overrun", 24'(overrun), 24'd1);
        chk("f8_ovr_cnt", 24'(overrun_cnt), 24'd2);
        chk("f8_tx_l_held", l_tx, 24'd1000);
        chk("f8_job_sample_held", bif.job_sample, 24'd100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_audio);
            chk("f8_hold", {busy, bif.job_valid, 2'(bif.job_src), bif.job_sample[19:0]},
                {1'b1, 1'b1, 2'd0, 20'd100});
        end
        ready_en = 1'b1;
        repeat (490) @(negedge clk_audio);

        // Frame 9: aborted job's result was discarded; only sources 2 and 3 mixed
        pulse_frame(24'sd0, 24'sd0, 4'b0000);
        chk("f9_tx_l", l_tx, 24'd700);
        chk("f9_tx_r", r_tx, 24'd700);
        chk("f9_ovr_cnt", 24'(overrun_cnt), 24'd2);
        chk("f9_frame_cnt", 24'(frame_count), 24'd9);
        repeat (20) @(negedge clk_audio);
        chk("jobs_outstanding", 24'(exp_src_q.size()), 24'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
